// File: rtl/zigzag_block_builder.sv
// Run/level symbol to raster-order 8x8 block builder with ping-pong banks.
// One bank fills in zig-zag order while the other waits to be consumed downstream.
module zigzag_block_builder #(
    parameter int COEF_W = 12,
    parameter int RUN_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RUN_W-1:0]      in_run,
    input  logic [COEF_W-1:0]     in_coef,
    input  logic                  in_eob,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*COEF_W-1:0]  out_block,
    output logic                  out_err
);

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL
    } bank_state_e;

    // Wide enough that pos + in_run never wraps, whatever RUN_W is.
    localparam int TGT_W = ((RUN_W > 7) ? RUN_W : 7) + 1;

    localparam logic [5:0] ZZ_TABLE [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [6:0]           pos_q, pos_d;
    logic                 fill_sel_q, fill_sel_d;
    logic                 out_sel_q, out_sel_d;

    logic [64*COEF_W-1:0] bank_mem [2];
    logic [1:0]           bank_full;
    logic [1:0]           bank_err;

    logic [TGT_W-1:0]     target;
    logic                 overflow;
    logic                 last_pos;
    logic                 close_block;
    logic [5:0]           wr_idx;
    logic                 in_fire;
    logic                 out_fire;

    assign target      = TGT_W'(pos_q) + TGT_W'(in_run);
    assign overflow    = target > TGT_W'(63);
    assign last_pos    = target == TGT_W'(63);
    assign close_block = in_eob || overflow || last_pos;
    assign wr_idx      = ZZ_TABLE[target[5:0]];

    // Ping-pong order guarantees the output bank always holds the oldest block.
    assign in_ready  = !rst && !bank_full[fill_sel_q];
    assign out_valid = !rst && bank_full[out_sel_q];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_block = rst ? '0 : bank_mem[out_sel_q];
    assign out_err   = out_valid && bank_err[out_sel_q];

    always_comb begin
        pos_d      = pos_q;
        fill_sel_d = fill_sel_q;
        out_sel_d  = out_sel_q;
        if (in_fire) begin
            if (close_block) begin
                pos_d      = '0;
                fill_sel_d = ~fill_sel_q;
            end else begin
                pos_d = 7'(target + TGT_W'(1));
            end
        end
        if (out_fire) begin
            out_sel_d = ~out_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q      <= '0;
            fill_sel_q <= 1'b0;
            out_sel_q  <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            fill_sel_q <= fill_sel_d;
            out_sel_q  <= out_sel_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [64*COEF_W-1:0] mem_q, mem_d;
        bank_state_e          state_q, state_d;
        logic                 err_q, err_d;
        logic                 is_fill;
        logic                 is_out;

        assign is_fill = fill_sel_q == 1'(gi);
        assign is_out  = out_sel_q == 1'(gi);

        // Fill and drain never target the same bank in one cycle, so order here is free.
        always_comb begin
            mem_d   = mem_q;
            state_d = state_q;
            err_d   = err_q;
            if (out_fire && is_out) begin
                mem_d   = '0;
                state_d = BANK_FREE;
                err_d   = 1'b0;
            end
            if (in_fire && is_fill) begin
                if (in_eob) begin
                    state_d = BANK_FULL;
                end else if (overflow) begin
                    state_d = BANK_FULL;
                    err_d   = 1'b1;
                end else begin
                    mem_d[32'(wr_idx)*COEF_W +: COEF_W] = in_coef;
                    state_d = last_pos ? BANK_FULL : BANK_FILLING;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                mem_q   <= '0;
                state_q <= BANK_FREE;
                err_q   <= 1'b0;
            end else begin
                mem_q   <= mem_d;
                state_q <= state_d;
                err_q   <= err_d;
            end
        end

        assign bank_mem[gi]  = mem_q;
        assign bank_full[gi] = state_q == BANK_FULL;
        assign bank_err[gi]  = err_q;
    end

endmodule

// File: tb/tb_zigzag_block_builder.sv
// Scoreboard bench: a zig-zag reference model pushes expected blocks, a monitor pops them.
module tb_zigzag_block_builder;

    localparam int COEF_W = 12;
    localparam int RUN_W  = 4;
    localparam int BW     = 64 * COEF_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [RUN_W-1:0]  in_run = '0;
    logic [COEF_W-1:0] in_coef = '0;
    logic              in_eob = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BW-1:0]     out_block;
    logic              out_err;

    zigzag_block_builder #(.COEF_W(COEF_W), .RUN_W(RUN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_run    (in_run),
        .in_coef   (in_coef),
        .in_eob    (in_eob),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] blk;
        logic          err;
    } exp_t;

    exp_t              exp_q[$];
    int                zz_raster[64];
    logic [COEF_W-1:0] zz_buf[64];
    int                m_pos;
    bit                m_err;
    int                blocks_done = 0;
    int                errors = 0;
    int                checks = 0;
    int                ready_mode = 1;   // 0 hold low, 1 hold high, 2 random

    // Zig-zag order derived by walking anti-diagonals, alternating direction.
    function automatic void build_zz();
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_raster[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_raster[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 64; k++) zz_buf[k] = '0;
        m_pos = 0;
        m_err = 1'b0;
    endfunction

    function automatic void model_close();
        exp_t e;
        e.blk = '0;
        for (int k = 0; k < 64; k++) e.blk[zz_raster[k]*COEF_W +: COEF_W] = zz_buf[k];
        e.err = m_err;
        exp_q.push_back(e);
        blocks_done++;
        model_clear();
    endfunction

    function automatic void model_accept(input bit eob, input int run, input logic [COEF_W-1:0] coef);
        if (eob) begin
            model_close();
        end else if (m_pos + run > 63) begin
            m_err = 1'b1;
            model_close();
        end else begin
            zz_buf[m_pos + run] = coef;
            m_pos = m_pos + run + 1;
            if (m_pos == 64) model_close();
        end
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_ready();
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic send_sym(input bit eob, input int run, input int coef);
        int waited;
        waited = 0;
        @(negedge clk);
        drive_ready();
        in_valid = 1'b1;
        in_eob   = eob;
        in_run   = RUN_W'(run);
        in_coef  = COEF_W'(coef);
        #1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            drive_ready();
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(eob, run, COEF_W'(coef));
            $display("sym eob=%0d run=%0d coef=%0h pos_after=%0d pending=%0d", eob, run, COEF_W'(coef), m_pos, exp_q.size());
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_ready();
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        drive_ready();
        exp_q.delete();
        model_clear();
        repeat (n - 1) begin
            @(negedge clk);
            drive_ready();
        end
        @(negedge clk);
        rst = 1'b0;
        drive_ready();
    endtask

    // Monitor: model's pending-block count defines in_ready/out_valid every cycle.
    initial begin
        logic exp_rdy;
        logic exp_val;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                chk("rst_in_ready", BW'(in_ready), BW'(0));
                chk("rst_out_valid", BW'(out_valid), BW'(0));
                chk("rst_out_err", BW'(out_err), BW'(0));
                chk("rst_out_block", out_block, '0);
            end else begin
                exp_rdy = exp_q.size() < 2;
                exp_val = exp_q.size() > 0;
                chk("in_ready", BW'(in_ready), BW'(exp_rdy));
                chk("out_valid", BW'(out_valid), BW'(exp_val));
                if (out_valid && exp_q.size() > 0) begin
                    chk("out_block", out_block, exp_q[0].blk);
                    chk("out_err", BW'(out_err), BW'(exp_q[0].err));
                    if (out_ready) begin
                        $display("blk out err=%0d remaining=%0d", out_err, exp_q.size() - 1);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int target;
        int guard;
        build_zz();
        model_clear();
        do_reset(3);

        // Short block with a negative coefficient and a run.
        ready_mode = 1;
        send_sym(0, 0, 5);
        send_sym(0, 0, -3);
        send_sym(0, 1, 7);
        send_sym(1, 0, 0);
        idle(3);

        // Full 64-entry block closes without EOB.
        for (int i = 0; i < 64; i++) send_sym(0, 0, i + 1);
        idle(3);

        // Back-pressure: two blocks fill both banks, then release.
        ready_mode = 0;
        send_sym(0, 0, 11);
        send_sym(1, 0, 0);
        send_sym(0, 2, 22);
        send_sym(1, 0, 0);
        idle(2);
        chk("both_full_in_ready", BW'(in_ready), BW'(0));
        ready_mode = 1;
        send_sym(0, 0, 33);
        send_sym(1, 0, 0);
        idle(4);

        // Overflow at pos 60, then a clean block.
        send_sym(0, 15, 1);
        send_sym(0, 15, 2);
        send_sym(0, 15, 3);
        send_sym(0, 11, 4);
        send_sym(0, 5, 99);
        send_sym(0, 0, 7);
        send_sym(1, 0, 0);
        idle(3);

        // Reset mid-block discards the partial block.
        for (int i = 0; i < 10; i++) send_sym(0, i % 3, 100 + i);
        do_reset(2);
        send_sym(1, 0, 0);
        idle(3);

        // Completion and output handshake on the same edge.
        ready_mode = 0;
        send_sym(1, 0, 0);
        send_sym(0, 0, 1);
        send_sym(0, 0, 2);
        ready_mode = 1;
        send_sym(1, 0, 0);
        idle(3);

        // Randomized blocks with random back-pressure.
        ready_mode = 2;
        for (int b = 0; b < 40; b++) begin
            target = blocks_done + 1;
            guard  = 0;
            while (blocks_done < target && guard < 200) begin
                send_sym($urandom_range(0, 19) == 0,
                         ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 4095)));
                guard++;
            end
        end

        ready_mode = 1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        chk("drain_empty", BW'(exp_q.size()), BW'(0));
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zigzag_block_builder.md
ZIGZAG_BLOCK_BUILDER -- requirements
Module: zigzag_block_builder

Interface
REQ-001 SHALL have parameter COEF_W, default 12, coefficient width in bits (signed, two's complement).
REQ-002 SHALL have parameter RUN_W, default 4, zero-run field width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, symbol present.
REQ-006 SHALL have port in_ready, output, 1, symbol accepted when in_valid && in_ready at rising edge.
REQ-007 SHALL have port in_run, input, RUN_W, zero coefficients preceding in_coef in zig-zag order.
REQ-008 SHALL have port in_coef, input, COEF_W, coefficient value.
REQ-009 SHALL have port in_eob, input, 1, end-of-block marker; in_run and in_coef ignored when set.
REQ-010 SHALL have port out_valid, output, 1, completed block available.
REQ-011 SHALL have port out_ready, input, 1, block consumed when out_valid && out_ready at rising edge.
REQ-012 SHALL have port out_block, output, 64*COEF_W, raster-order block; element (r,c) at bits [(8*r+c)*COEF_W +: COEF_W].
REQ-013 SHALL have port out_err, output, 1, qualified by out_valid; set when the presented block overflowed.

Function
REQ-014 SHALL hold two block banks (ping-pong), each 64 x COEF_W, plus per-bank state FREE, FILLING or FULL and an err bit.
REQ-015 SHALL keep a 7-bit zig-zag position pos (0..64) for the filling bank.
REQ-016 SHALL map zig-zag position k to raster index using the standard JPEG zig-zag table (k=0->0, 1->1, 2->8, 3->16, 4->9, 5->2, ..., 63->63).
REQ-017 On an accepted non-EOB symbol with pos+in_run <= 63: SHALL write in_coef to raster(zz[pos+in_run]) and set pos to pos+in_run+1.
REQ-018 When pos reaches 64 through REQ-017: SHALL mark the bank FULL, reset pos to 0 and select the other bank for filling.
REQ-019 On an accepted EOB: SHALL mark the bank FULL with all unwritten positions zero, reset pos to 0 and switch bank; EOB with pos=0 SHALL produce an all-zero block.
REQ-020 On an accepted non-EOB symbol with pos+in_run > 63: SHALL discard the coefficient, set that bank's err bit, mark the bank FULL, reset pos to 0 and switch bank.
REQ-021 in_ready SHALL be 1 exactly when the fill bank is FREE or FILLING and rst is 0.
REQ-022 out_valid SHALL be 1 exactly when the oldest FULL bank exists; out_block and out_err SHALL be driven from it and held stable while out_valid && !out_ready.
REQ-023 Latency: out_valid SHALL rise in the cycle after the block-completing symbol is accepted.
REQ-024 Blocks SHALL be presented strictly in completion order.
REQ-025 On output handshake: the bank SHALL become FREE with all 64 entries and err cleared in the same edge.
REQ-026 With both banks FULL, in_ready SHALL be 0; a same-cycle output handshake frees a bank, and in_ready SHALL be 1 in the following cycle.
REQ-027 An input symbol completing a block and an output handshake in the same cycle SHALL both take effect with no loss.
REQ-028 in_coef SHALL be stored bit-exact with no sign extension or truncation.

Reset
REQ-029 While rst=1: in_ready=0, out_valid=0, out_err=0, out_block=0, pos=0, both banks FREE and zeroed; bank 0 SHALL be the first fill bank.
REQ-030 Reset asserted mid-block or with blocks pending SHALL discard all content; no partial block SHALL be output after reset.

Verification
REQ-031 Symbols (run0,5),(run0,-3),(run1,7),EOB -> one block: raster[0]=5, raster[1]=-3, raster[16]=7, all others 0, out_err=0.
REQ-032 64 symbols run0 with values 1..64 -> block completes without EOB; raster(zz[k])=k+1; out_valid the cycle after the 64th accept.
REQ-033 out_ready=0, three consecutive EOB-terminated blocks -> in_ready drops after the second block completes; raising out_ready releases blocks in order with no data loss.
REQ-034 pos=60 then symbol run=5 -> block closed, out_err=1, coefficient not written; next block starts at pos 0 with out_err=0.
REQ-035 rst pulsed after 10 symbols of a block -> out_valid=0, in_ready=0 during reset, 1 next cycle; a following EOB yields an all-zero block.
REQ-036 Completing symbol and output handshake in the same cycle with both banks otherwise FULL -> both blocks delivered intact, in_ready never erroneously 1.
